demux_dispatch: RTL



---
 rtl/demux_dispatch.sv | 119 +++++++++++
 1 files changed

// File: rtl/demux_dispatch.sv
// demux_dispatch: FIFO-buffered, glitch-safe sel/data sequencer driving a 1:8 demux stage
//   Ports: clk, rst_n (async active-low); req_valid/req_ready/req_dest/req_bit request handshake;
//   sel/dmx_in to the demux pins; busy (FSM not idle); done (one-cycle end strobe);
//   fifo_level (entries stored); dispatch_cnt (saturating done count, only with DEMUX_DISPATCH_CNT_EN).
`timescale 1ns/1ps
module demux_dispatch #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_dest,
  input  logic                     req_bit,
  output logic [2:0]               sel,
  output logic                     dmx_in,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef DEMUX_DISPATCH_CNT_EN
  ,
  output logic [15:0]              dispatch_cnt
`endif
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_END} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic            dmx_q, dmx_d, bit_q, bit_d, done_q, done_d, busy_q;
  logic [3:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [LW-1:0]   level_q;
  logic            push, pop;
  logic [3:0]      head;
  // ready is held low during reset so nothing is accepted while the FIFO is being cleared
  assign req_ready  = rst_n && (level_q < LW'(DEPTH));
  assign push       = req_valid && req_ready;
  assign head       = mem_q[rd_q];
  assign fifo_level = level_q;
  assign sel        = sel_q;
  assign dmx_in     = dmx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {req_dest, req_bit};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= push ? wr_q + AW'(1) : wr_q;
      rd_q    <= pop ? rd_q + AW'(1) : rd_q;
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  // dmx_in is only raised on the SETUP->PULSE edge, never on a pop, so it is never high while sel moves
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dmx_d   = dmx_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE, S_END: begin
        pop     = level_q != '0;
        state_d = pop ? S_SETUP : S_IDLE;
        sel_d   = pop ? head[3:1] : sel_q;
        bit_d   = pop ? head[0] : bit_q;
        cnt_d   = pop ? CW'(SETUP_CYC) : cnt_q;
        dmx_d   = 1'b0;
      end
      S_SETUP: begin
        state_d = (cnt_q == CW'(1)) ? S_PULSE : S_SETUP;
        dmx_d   = (cnt_q == CW'(1)) ? bit_q : 1'b0;
        cnt_d   = (cnt_q == CW'(1)) ? CW'(HOLD_CYC) : cnt_q - CW'(1);
      end
      S_PULSE: begin
        state_d = (cnt_q == CW'(1)) ? S_END : S_PULSE;
        dmx_d   = (cnt_q == CW'(1)) ? 1'b0 : dmx_q;
        done_d  = cnt_q == CW'(1);
        cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      dmx_q   <= 1'b0;
      bit_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dmx_q   <= dmx_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      busy_q  <= state_d != S_IDLE;
    end
`ifdef DEMUX_DISPATCH_CNT_EN
  logic [15:0] dcnt_q;
  assign dispatch_cnt = dcnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dcnt_q <= '0;
    else if (done_d && dcnt_q != 16'hFFFF) dcnt_q <= dcnt_q + 16'd1;
`endif
endmodule
